prog_instr_mem: RTL

Parametrised instruction memory for the GPP. It is loaded by a streaming valid/ready word interface instead of a fixed file read, tracks the loaded program length, and serves fetch requests with one-cycle registered latency. A fetch past the end of the program or outside memory does not return stale data: it returns a configurable NOP and raises a fault flag. Sits between the program loader or testbench and the fetch stage; branch targets drive fetch_addr directly.

---
 rtl/prog_instr_mem_if.sv | 34 +++
 rtl/prog_instr_mem.sv | 86 ++++++++
 2 files changed

// File: rtl/prog_instr_mem_if.sv
// Load-stream and fetch signals of the instruction memory. The master side
// belongs to the loader/fetch stage and the slave side to the memory.
interface prog_instr_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   prog_len;
    logic              load_ovf;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_ready, load_done, prog_len, load_ovf,
        input  fetch_valid, fetch_instr, fetch_fault
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_ready, load_done, prog_len, load_ovf,
        output fetch_valid, fetch_instr, fetch_fault
    );
endinterface

// File: rtl/prog_instr_mem.sv
// Instruction memory filled by a valid/ready word stream; serves fetches with
// one cycle of latency and substitutes NOP_WORD for addresses past the program.
module prog_instr_mem #(
    parameter int                 DATA_W   = 16,
    parameter int                 DEPTH    = 512,
    parameter int                 ADDR_W   = 9,
    parameter logic [DATA_W-1:0]  NOP_WORD = 16'h0000
) (
    input logic             clk,
    input logic             rst,
    prog_instr_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   len_reg;
    logic              ovf_reg;
    logic              valid_reg;
    logic              fault_reg;
    logic              nop_sel_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic beat, has_room, fetch_go, in_range;

    // load_start pre-empts any beat presented in the same cycle
    assign beat     = (state_reg == LOAD) && bus.load_valid && !bus.load_start;
    assign has_room = len_reg < DEPTH_L;
    assign fetch_go = bus.fetch_req && (state_reg != LOAD);
    assign in_range = {1'b0, bus.fetch_addr} < len_reg;

    always_comb begin
        state_next = state_reg;
        if (bus.load_start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD:    if (beat && bus.load_last) state_next = READY;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            ovf_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            nop_sel_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            valid_reg <= fetch_go;
            if (fetch_go) begin
                fault_reg   <= !in_range;
                nop_sel_reg <= !in_range;
            end
            if (bus.load_start) begin
                len_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (beat) begin
                if (has_room) len_reg <= len_reg + 1'b1;
                else          ovf_reg <= 1'b1;
            end
        end
    end

    // Plain RAM process: one write port, one registered read port, no reset
    always_ff @(posedge clk) begin
        if (beat && has_room)
            mem[len_reg[ADDR_W-1:0]] <= bus.load_data;
        if (fetch_go && in_range)
            rd_data_reg <= mem[bus.fetch_addr];
    end

    assign bus.load_ready  = (state_reg == LOAD);
    assign bus.load_done   = (state_reg == READY);
    assign bus.prog_len    = len_reg;
    assign bus.load_ovf    = ovf_reg;
    assign bus.fetch_valid = valid_reg;
    assign bus.fetch_fault = fault_reg;
    assign bus.fetch_instr = nop_sel_reg ? NOP_WORD : rd_data_reg;
endmodule
